// File: rtl/aes_round_sched.sv
// Round/step scheduler for the AES-256 core: sequences LOAD, NR rounds of five
// steps and a final column flush, emitting write strobes aligned to the registered S-Box.
module aes_round_sched #(
  parameter int NR = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stall,
  output logic [3:0] rnd_cnt,
  output logic [2:0] step,
  output logic       busy,
  output logic       load_state,
  output logic       key_wr,
  output logic       col_wr,
  output logic [1:0] col_idx,
  output logic       last_round,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FLUSH, DONE} state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t     state, nstate;
  logic [3:0] nrnd;
  logic [2:0] nstep;
  logic       nkey, ncol;
  logic [1:0] nidx;
  logic       key_q, col_q;

  always_comb begin
    nstate = state;
    nrnd   = rnd_cnt;
    nstep  = step;
    case (state)
      IDLE: begin
        nrnd  = 4'd0;
        nstep = 3'd0;
        if (start) nstate = LOAD;
      end
      LOAD: begin
        nstate = ROUND;
        nrnd   = 4'd1;
        nstep  = 3'd0;
      end
      ROUND: begin
        if (!stall) begin
          if (step == 3'd4) begin
            nstep = 3'd0;
            if (rnd_cnt == NR_L) nstate = FLUSH;
            else                 nrnd   = rnd_cnt + 4'd1;
          end else begin
            nstep = step + 3'd1;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          nstate = DONE;
          nrnd   = 4'd0;
        end
      end
      DONE: begin
        nstate = IDLE;
        nrnd   = 4'd0;
        nstep  = 3'd0;
      end
      default: begin
        nstate = IDLE;
        nrnd   = 4'd0;
        nstep  = 3'd0;
      end
    endcase

    // S-Box result lags one step: step 0 writes back the previous round's column 3
    nkey = (nstate == ROUND) && (nstep == 3'd1);
    ncol = ((nstate == ROUND) && ((nstep >= 3'd2) || ((nstep == 3'd0) && (nrnd >= 4'd2))))
           || (nstate == FLUSH);
    nidx = ((nstate == ROUND) && (nstep >= 3'd2)) ? 2'(nstep - 3'd2)
                                                  : (ncol ? 2'd3 : 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rnd_cnt    <= 4'd0;
      step       <= 3'd0;
      busy       <= 1'b0;
      load_state <= 1'b0;
      key_q      <= 1'b0;
      col_q      <= 1'b0;
      col_idx    <= 2'd0;
      last_round <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nstate;
      rnd_cnt    <= nrnd;
      step       <= nstep;
      busy       <= (nstate == LOAD) || (nstate == ROUND) || (nstate == FLUSH);
      load_state <= (nstate == LOAD);
      key_q      <= nkey;
      col_q      <= ncol;
      col_idx    <= nidx;
      last_round <= ((nstate == ROUND) || (nstate == FLUSH)) && (nrnd == NR_L);
      done       <= (nstate == DONE);
    end
  end

  // Strobes only exist in ROUND/FLUSH, so gating by stall alone suppresses a held step
  assign key_wr = key_q & ~stall;
  assign col_wr = col_q & ~stall;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: NR=14 and NR=10 instances share stimulus and are
// compared every cycle against a position-based model of the schedule.
module tb_aes_round_sched;

  logic clk = 1'b0;
  logic reset, start, stall;
  always #5 clk = ~clk;

  logic [3:0] rnd14, rnd10;
  logic [2:0] step14, step10;
  logic       busy14, load14, key14, col14, last14, done14;
  logic       busy10, load10, key10, col10, last10, done10;
  logic [1:0] idx14, idx10;
  logic [14:0] o14, o10;

  aes_round_sched #(.NR(14)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .rnd_cnt(rnd14), .step(step14), .busy(busy14), .load_state(load14),
    .key_wr(key14), .col_wr(col14), .col_idx(idx14), .last_round(last14), .done(done14)
  );

  aes_round_sched #(.NR(10)) dut10 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .rnd_cnt(rnd10), .step(step10), .busy(busy10), .load_state(load10),
    .key_wr(key10), .col_wr(col10), .col_idx(idx10), .last_round(last10), .done(done10)
  );

  assign o14 = {rnd14, step14, busy14, load14, key14, col14, idx14, last14, done14};
  assign o10 = {rnd10, step10, busy10, load10, key10, col10, idx10, last10, done10};

  int p14, p10, cyc, tests, fails;

  // Position p: 0 idle, 1 load, 2..5nr+1 round steps, 5nr+2 flush, 5nr+3 done
  function automatic logic [14:0] exp_vec(int p, int nr, logic stl);
    logic [3:0] r = 4'd0;
    logic [2:0] s = 3'd0;
    logic b = 1'b0, ld = 1'b0, k = 1'b0, c = 1'b0, lr = 1'b0, d = 1'b0;
    logic [1:0] ix = 2'd0;
    if (p == 1) begin
      b = 1'b1; ld = 1'b1;
    end else if (p >= 2 && p <= 5*nr+1) begin
      r  = 4'((p-2)/5 + 1);
      s  = 3'((p-2)%5);
      b  = 1'b1;
      k  = (s == 3'd1);
      c  = (s >= 3'd2) || (s == 3'd0 && r >= 4'd2);
      ix = (s >= 3'd2) ? 2'(s - 3'd2) : (c ? 2'd3 : 2'd0);
      lr = (int'(r) == nr);
      if (stl) begin k = 1'b0; c = 1'b0; end
    end else if (p == 5*nr+2) begin
      r = 4'(nr); b = 1'b1; c = !stl; ix = 2'd3; lr = 1'b1;
    end else if (p == 5*nr+3) begin
      d = 1'b1;
    end
    return {r, s, b, ld, k, c, ix, lr, d};
  endfunction

  function automatic int adv(int p, int nr, logic st, logic sl, logic rs);
    if (rs) return 0;
    if (p == 0) return st ? 1 : 0;
    if (p == 5*nr+3) return 0;
    if (p >= 2 && sl) return p;
    return p + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    p14 = adv(p14, 14, start, stall, reset);
    p10 = adv(p10, 10, start, stall, reset);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic rst_cycle();
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      reset = 1'b1; start = 1'($urandom); stall = 1'($urandom);
      tick();
      tests++;
      if ({o14, o10} !== 30'd0) begin
        fails++;
        $display("FAIL reset i=%0d got=%h/%h exp=0/0", i, o14, o10);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int nkey = 0, ncol = 0, nbusy = 0, nload = 0, loadc = -1, d14 = -1, d10 = -1, seq = 0, nlast10 = 0;
    rst_cycle();
    for (int i = 0; i < 80; i++) begin
      start = (i == 0); stall = 1'b0;
      #1;
      tests++;
      if ({o14, o10} !== {exp_vec(p14, 14, stall), exp_vec(p10, 10, stall)}) begin
        fails++;
        $display("FAIL single cyc=%0d got=%h/%h exp=%h/%h", cyc, o14, o10,
                 exp_vec(p14, 14, stall), exp_vec(p10, 10, stall));
      end
      if (col14) begin
        tests++;
        if (idx14 !== 2'(seq % 4)) begin
          fails++;
          $display("FAIL col_seq cyc=%0d got=%0d exp=%0d", cyc, idx14, seq % 4);
        end
        seq++; ncol++;
      end
      if (busy14 && rnd14 == 4'd5 && step14 == 3'd0) begin
        tests++;
        if ({col14, idx14, key14} !== 4'b1110) begin
          fails++;
          $display("FAIL r5s0 got=%b exp=1110", {col14, idx14, key14});
        end
      end
      if (busy14 && rnd14 == 4'd1 && step14 == 3'd0) begin
        tests++;
        if ({col14, key14} !== 2'b00) begin
          fails++;
          $display("FAIL r1s0 got=%b exp=00", {col14, key14});
        end
      end
      if (last10) begin
        nlast10++;
        tests++;
        if (rnd10 !== 4'd10) begin
          fails++;
          $display("FAIL last10 got rnd=%0d exp=10", rnd10);
        end
      end
      if (key14) nkey++;
      if (busy14) nbusy++;
      if (load14) begin nload++; loadc = cyc; end
      if (done14) d14 = cyc;
      if (done10) d10 = cyc;
      tick();
    end
    tests += 7;
    if (nkey != 14)  begin fails++; $display("FAIL key_count got=%0d exp=14", nkey); end
    if (ncol != 56)  begin fails++; $display("FAIL col_count got=%0d exp=56", ncol); end
    if (nbusy != 72) begin fails++; $display("FAIL busy_count got=%0d exp=72", nbusy); end
    if (nload != 1 || loadc != 1) begin fails++; $display("FAIL load got=%0d@%0d exp=1@1", nload, loadc); end
    if (d14 != 73)   begin fails++; $display("FAIL done14 got=%0d exp=73", d14); end
    if (d10 != 53)   begin fails++; $display("FAIL done10 got=%0d exp=53", d10); end
    if (nlast10 != 6) begin fails++; $display("FAIL last10_count got=%0d exp=6", nlast10); end
  endtask

  task automatic test_stall();
    int d14 = -1, d10 = -1;
    rst_cycle();
    for (int i = 0; i < 85; i++) begin
      start = (i == 0); stall = (i >= 34 && i <= 36);
      #1;
      tests++;
      if ({o14, o10} !== {exp_vec(p14, 14, stall), exp_vec(p10, 10, stall)}) begin
        fails++;
        $display("FAIL stall cyc=%0d got=%h/%h exp=%h/%h", cyc, o14, o10,
                 exp_vec(p14, 14, stall), exp_vec(p10, 10, stall));
      end
      if (i >= 34 && i <= 36) begin
        tests++;
        if ({rnd14, step14, col14} !== {4'd7, 3'd2, 1'b0}) begin
          fails++;
          $display("FAIL stall_hold cyc=%0d got=%0d/%0d/%b exp=7/2/0", cyc, rnd14, step14, col14);
        end
      end
      if (i == 37) begin
        tests++;
        if ({col14, idx14} !== 3'b100) begin
          fails++;
          $display("FAIL stall_release got=%b exp=100", {col14, idx14});
        end
      end
      if (done14) d14 = cyc;
      if (done10) d10 = cyc;
      tick();
    end
    stall = 1'b0;
    tests += 2;
    if (d14 != 76) begin fails++; $display("FAIL stall_done14 got=%0d exp=76", d14); end
    if (d10 != 56) begin fails++; $display("FAIL stall_done10 got=%0d exp=56", d10); end
  endtask

  task automatic test_ignore_start();
    int nl14 = 0, nl10 = 0;
    rst_cycle();
    for (int i = 0; i < 135; i++) begin
      start = (i == 0 || i == 10 || i == 73); stall = 1'b0;
      #1;
      tests++;
      if ({o14, o10} !== {exp_vec(p14, 14, stall), exp_vec(p10, 10, stall)}) begin
        fails++;
        $display("FAIL ignore cyc=%0d got=%h/%h exp=%h/%h", cyc, o14, o10,
                 exp_vec(p14, 14, stall), exp_vec(p10, 10, stall));
      end
      if (load14) nl14++;
      if (load10) nl10++;
      tick();
    end
    start = 1'b0;
    tests += 2;
    if (nl14 != 1) begin fails++; $display("FAIL ignore_load14 got=%0d exp=1", nl14); end
    if (nl10 != 2) begin fails++; $display("FAIL ignore_load10 got=%0d exp=2", nl10); end
  endtask

  task automatic test_reset_mid();
    int d14 = -1;
    rst_cycle();
    for (int i = 0; i < 125; i++) begin
      start = (i == 0 || i == 47); stall = 1'b0; reset = (i == 45);
      #1;
      tests++;
      if ({o14, o10} !== {exp_vec(p14, 14, stall), exp_vec(p10, 10, stall)}) begin
        fails++;
        $display("FAIL reset_mid cyc=%0d got=%h/%h exp=%h/%h", cyc, o14, o10,
                 exp_vec(p14, 14, stall), exp_vec(p10, 10, stall));
      end
      if (i == 45) begin
        tests++;
        if ({rnd14, step14} !== {4'd9, 3'd3}) begin
          fails++;
          $display("FAIL reset_mid_pos got=%0d/%0d exp=9/3", rnd14, step14);
        end
      end
      if (i == 46) begin
        tests++;
        if ({o14, o10} !== 30'd0) begin
          fails++;
          $display("FAIL reset_mid_clear got=%h/%h exp=0/0", o14, o10);
        end
      end
      if (done14) d14 = cyc;
      tick();
    end
    reset = 1'b0; start = 1'b0;
    tests++;
    if (d14 != 120) begin fails++; $display("FAIL reset_mid_done got=%0d exp=120", d14); end
  endtask

  task automatic test_back_to_back();
    int loads[$];
    rst_cycle();
    for (int i = 0; i < 225; i++) begin
      start = 1'b1; stall = 1'b0;
      #1;
      tests++;
      if ({o14, o10} !== {exp_vec(p14, 14, stall), exp_vec(p10, 10, stall)}) begin
        fails++;
        $display("FAIL b2b cyc=%0d got=%h/%h exp=%h/%h", cyc, o14, o10,
                 exp_vec(p14, 14, stall), exp_vec(p10, 10, stall));
      end
      if (load14) loads.push_back(cyc);
      tick();
    end
    start = 1'b0;
    tests++;
    if (loads.size() != 4 || loads[0] != 1 || loads[1] != 75 || loads[2] != 149 || loads[3] != 223) begin
      fails++;
      $display("FAIL b2b_spacing got=%p exp=1,75,149,223", loads);
    end
  endtask

  task automatic test_random();
    rst_cycle();
    for (int i = 0; i < 800; i++) begin
      start = ($urandom % 8 == 0);
      stall = ($urandom % 4 == 0);
      reset = ($urandom % 50 == 0);
      #1;
      tests++;
      if ({o14, o10} !== {exp_vec(p14, 14, stall), exp_vec(p10, 10, stall)}) begin
        fails++;
        $display("FAIL random cyc=%0d got=%h/%h exp=%h/%h", cyc, o14, o10,
                 exp_vec(p14, 14, stall), exp_vec(p10, 10, stall));
      end
      tick();
    end
    reset = 1'b0; start = 1'b0; stall = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; p14 = 0; p10 = 0;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stall();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
